// File: rtl/video_line_prefetch_if.sv
// Bundle of the line-request, pixel-read and RAM-arbiter signals of video_line_prefetch.
// The slave modport is the prefetcher; the master modport is its surroundings.
interface video_line_prefetch_if #(
    parameter int LINE_WORDS = 32,
    parameter int ADDR_W     = 14
);
    localparam int LW = $clog2(LINE_WORDS);

    logic                 line_req;
    logic [ADDR_W-LW-1:0] line_addr;
    logic [ADDR_W-1:0]    vram_addr;
    logic [15:0]          vram_data;
    logic                 mem_rd;
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_ack;
    logic [15:0]          mem_din;
    logic                 underrun;

    modport slave (
        input  line_req, line_addr, vram_addr, mem_ack, mem_din,
        output vram_data, mem_rd, mem_addr, underrun
    );

    modport master (
        output line_req, line_addr, vram_addr, mem_ack, mem_din,
        input  vram_data, mem_rd, mem_addr, underrun
    );
endinterface

// File: rtl/video_line_prefetch.sv
// Ping-pong line prefetcher: fills one bank from shared video RAM while the pixel
// stage reads the other bank with one clock of latency.
module video_line_prefetch #(
    parameter int LINE_WORDS = 32,
    parameter int ADDR_W     = 14
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    video_line_prefetch_if.slave  bus
);
    localparam int              LW   = $clog2(LINE_WORDS);
    localparam int              LA_W = ADDR_W - LW;
    localparam logic [LW-1:0]   LAST = LW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t          state;
    logic            disp_bank;
    logic [LA_W-1:0] line_q;
    logic [LW-1:0]   cnt;

    logic [15:0]     line_buf [2*LINE_WORDS];
    logic            buf_we;
    logic [LW:0]     buf_waddr;
    logic [LW:0]     buf_raddr;

    // Line selection comes from line_addr; the pixel address only picks the word.
    logic            unused_vram_hi;
    assign unused_vram_hi = ^bus.vram_addr[ADDR_W-1:LW];

    // Only acks of a live fetch land in the fill bank; DRAIN acks are discarded.
    assign buf_we    = (state == FETCH) && bus.mem_ack;
    assign buf_waddr = {~disp_bank, cnt};
    assign buf_raddr = {disp_bank, bus.vram_addr[LW-1:0]};

    // NOTE: the line buffer has no reset so it maps onto plain RAM; stale words are legal.
    always_ff @(posedge clk_sys) begin
        if (buf_we) line_buf[buf_waddr] <= bus.mem_din;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            disp_bank     <= 1'b0;
            line_q        <= '0;
            cnt           <= '0;
            bus.mem_rd    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.underrun  <= 1'b0;
            bus.vram_data <= '0;
        end else begin
            bus.underrun  <= 1'b0;
            bus.vram_data <= line_buf[buf_raddr];
            case (state)
                IDLE: begin
                    if (bus.line_req) begin
                        disp_bank    <= ~disp_bank;
                        line_q       <= bus.line_addr;
                        cnt          <= '0;
                        bus.mem_rd   <= 1'b1;
                        bus.mem_addr <= {bus.line_addr, {LW{1'b0}}};
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.mem_ack) begin
                        if (bus.line_req) begin
                            // Nothing outstanding after this ack, so restart directly.
                            bus.underrun <= (cnt != LAST);
                            disp_bank    <= ~disp_bank;
                            line_q       <= bus.line_addr;
                            cnt          <= '0;
                            bus.mem_addr <= {bus.line_addr, {LW{1'b0}}};
                        end else if (cnt == LAST) begin
                            bus.mem_rd   <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            cnt          <= cnt + 1'b1;
                            bus.mem_addr <= {line_q, cnt + 1'b1};
                        end
                    end else if (bus.line_req) begin
                        bus.underrun <= 1'b1;
                        disp_bank    <= ~disp_bank;
                        line_q       <= bus.line_addr;
                        state        <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.line_req) begin
                        bus.underrun <= 1'b1;
                        disp_bank    <= ~disp_bank;
                        line_q       <= bus.line_addr;
                    end
                    if (bus.mem_ack) begin
                        cnt          <= '0;
                        bus.mem_addr <= {(bus.line_req ? bus.line_addr : line_q), {LW{1'b0}}};
                        state        <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_video_line_prefetch.sv
// Bench for video_line_prefetch: negedge RAM-arbiter model with an address scoreboard,
// table-driven line fetch/display vectors, and hand sequences for underrun and reset.
module tb_video_line_prefetch;
    localparam int LINE_WORDS = 32;
    localparam int ADDR_W     = 14;
    localparam int LW         = 5;
    localparam int LA_W       = ADDR_W - LW;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b1;

    video_line_prefetch_if #(.LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) bus ();

    video_line_prefetch #(.LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_total    = 0;
    int underrun_cnt = 0;
    int ack_gap   = 0;
    bit ack_rand  = 1'b0;
    int rnd_delay = 0;
    int arb_mode  = 1;            // 0 silent, 1 normal arbiter, 2 stray acks

    logic [ADDR_W-1:0] addr_q[$]; // expected mem_addr of each future ack
    logic [15:0]       read_q[$]; // expected vram_data of each issued read

    typedef struct {
        logic [LA_W-1:0]   line;
        int                gap;
        logic [ADDR_W-1:0] vaddr;
        logic [15:0]       exp;
    } vec_t;
    vec_t tbl[6];

    // Odd multiplier keeps the map injective, so every RAM word is distinct.
    function automatic logic [15:0] ram_word(input logic [ADDR_W-1:0] a);
        return 16'(32'(a) * 32'd40503 + 32'h1234);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push_line(input logic [LA_W-1:0] la);
        for (int w = 0; w < LINE_WORDS; w++) addr_q.push_back({la, 5'(w)});
    endtask

    task automatic pulse_line(input logic [LA_W-1:0] la);
        bus.line_addr = la;
        bus.line_req  = 1'b1;
        push_line(la);
        tick();
        bus.line_req  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (bus.mem_rd && n < budget) begin
            tick();
            n++;
        end
        if (bus.mem_rd) fail_now({name, "_timeout"});
        check({name, "_sb_drained"}, 32'(addr_q.size()), 32'd0);
    endtask

    task automatic read_check(input string name, input logic [ADDR_W-1:0] va, input logic [15:0] exp);
        bus.vram_addr = va;
        read_q.push_back(exp);
        tick();
        check(name, 32'(bus.vram_data), 32'(read_q.pop_front()));
    endtask

    // RAM arbiter model: drives acks at negedge, scores mem_addr, watches stability.
    initial begin : arbiter
        int wait_cnt = 0;
        int lim;
        bit pend = 1'b0;
        logic [ADDR_W-1:0] addr_prev = '0;
        bus.mem_ack = 1'b0;
        bus.mem_din = '0;
        forever begin
            @(negedge clk_sys);
            if (bus.underrun) underrun_cnt++;
            if (reset_n && pend && bus.mem_rd)
                check("addr_stable_while_pending", 32'(bus.mem_addr), 32'(addr_prev));
            pend = 1'b0;
            bus.mem_ack = 1'b0;
            lim = ack_rand ? rnd_delay : ack_gap;
            if (arb_mode == 2) begin
                bus.mem_ack = 1'b1;
                bus.mem_din = 16'hDEAD;
            end else if (arb_mode == 1 && reset_n && bus.mem_rd) begin
                if (wait_cnt >= lim) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_din = ram_word(bus.mem_addr);
                    if (addr_q.size() == 0) fail_now("unexpected_mem_rd");
                    else check("mem_addr_seq", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
                    ack_total++;
                    wait_cnt  = 0;
                    rnd_delay = $urandom_range(5, 0);
                end else begin
                    wait_cnt++;
                    pend = 1'b1;
                    addr_prev = bus.mem_addr;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base, base_u, k, n;
        logic [ADDR_W-1:0] outstanding;
        logic [LA_W-1:0]   prev;
        logic [LA_W-1:0]   la;
        logic [4:0]        idx;

        tbl[0] = '{line: 9'h107, gap: 1, vaddr: 14'h0003, exp: 16'h0};
        tbl[1] = '{line: 9'h1FF, gap: 3, vaddr: 14'h3FFF, exp: 16'h0};
        tbl[2] = '{line: 9'h000, gap: 0, vaddr: 14'h1FE0, exp: 16'h0};
        tbl[3] = '{line: 9'h0AA, gap: 2, vaddr: 14'h0150, exp: 16'h0};
        tbl[4] = '{line: 9'h155, gap: 5, vaddr: 14'h2A1E, exp: 16'h0};
        tbl[5] = '{line: 9'h0FF, gap: 4, vaddr: 14'h0001, exp: 16'h0};
        // Each line_req displays the line fetched by the previous one.
        prev = 9'h106;
        for (int i = 0; i < 6; i++) begin
            tbl[i].exp = ram_word({prev, tbl[i].vaddr[LW-1:0]});
            prev = tbl[i].line;
        end

        bus.line_req  = 1'b0;
        bus.line_addr = '0;
        bus.vram_addr = '0;

        // Reset state
        #1 reset_n = 1'b0;
        repeat (2) tick();
        check("rst_vram_data", 32'(bus.vram_data), 32'd0);
        check("rst_mem_rd",    32'(bus.mem_rd),    32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_underrun",  32'(bus.underrun),  32'd0);
        reset_n = 1'b1;
        tick();

        // 1: full fetch with ack every clock
        ack_gap = 0;
        base = ack_total;
        base_u = underrun_cnt;
        pulse_line(9'h105);
        check("t1_mem_rd_start",   32'(bus.mem_rd),   32'd1);
        check("t1_mem_addr_start", 32'(bus.mem_addr), 32'h20A0);
        wait_idle("t1", 100);
        check("t1_ack_count", 32'(ack_total - base), 32'd32);
        check("t1_no_underrun", 32'(underrun_cnt - base_u), 32'd0);

        // 2: display the fetched line while the next one fills
        pulse_line(9'h106);
        read_check("t2_word7", 14'h0007, ram_word(14'h20A7));
        read_check("t2_word0", 14'h3FC0, ram_word(14'h20A0));
        read_check("t2_word31", 14'h001F, ram_word(14'h20BF));
        wait_idle("t2", 100);

        // Table: fetch at various ack gaps, read back the previously fetched line
        for (int i = 0; i < 6; i++) begin
            ack_gap = tbl[i].gap;
            pulse_line(tbl[i].line);
            read_check($sformatf("tbl%0d_read", i), tbl[i].vaddr, tbl[i].exp);
            wait_idle($sformatf("tbl%0d", i), 400);
        end

        // 3: slow arbiter, line_req mid-fetch with a request outstanding
        ack_gap = 6;
        base = ack_total;
        base_u = underrun_cnt;
        pulse_line(9'h0A0);
        repeat (99) tick();
        n = 0;
        do begin
            @(negedge clk_sys);
            #1;
            n++;
        end while (bus.mem_ack && n < 10);
        k = ack_total - base;
        outstanding = addr_q[0];
        addr_q.delete();
        addr_q.push_back(outstanding);
        pulse_line(9'h0B0);
        check("t3_underrun_pulse", 32'(bus.underrun), 32'd1);
        check("t3_drain_mem_rd",   32'(bus.mem_rd),   32'd1);
        check("t3_drain_addr",     32'(bus.mem_addr), 32'(outstanding));
        read_check("t3_partial_last", {9'h0, 5'(k - 1)}, ram_word({9'h0A0, 5'(k - 1)}));
        check("t3_underrun_one_clk", 32'(bus.underrun), 32'd0);
        read_check("t3_stale_k",  {9'h0, 5'(k)}, ram_word({tbl[4].line, 5'(k)}));
        read_check("t3_stale_31", 14'h001F, ram_word({tbl[4].line, 5'd31}));
        wait_idle("t3", 1000);
        check("t3_underrun_count", 32'(underrun_cnt - base_u), 32'd1);

        // 4: line_req coincident with the final ack
        ack_gap = 0;
        base_u = underrun_cnt;
        pulse_line(9'h0C0);
        read_check("t3_refetch_word5", 14'h0005, ram_word({9'h0B0, 5'd5}));
        n = 0;
        do begin
            @(negedge clk_sys);
            #1;
            n++;
        end while (!(bus.mem_ack && addr_q.size() == 0) && n < 100);
        if (!(bus.mem_ack && addr_q.size() == 0)) fail_now("t4_final_ack_timeout");
        bus.line_addr = 9'h0D0;
        bus.line_req  = 1'b1;
        push_line(9'h0D0);
        tick();
        bus.line_req  = 1'b0;
        check("t4_no_underrun", 32'(bus.underrun), 32'd0);
        check("t4_mem_rd",      32'(bus.mem_rd),   32'd1);
        check("t4_mem_addr",    32'(bus.mem_addr), 32'h1A00);
        read_check("t4_word31", 14'h001F, ram_word({9'h0C0, 5'd31}));
        read_check("t4_word0",  14'h0000, ram_word({9'h0C0, 5'd0}));
        wait_idle("t4", 100);
        check("t4_underrun_count", 32'(underrun_cnt - base_u), 32'd0);

        // 5: reset mid-fetch, stray acks afterwards, then a clean fetch
        base = ack_total;
        pulse_line(9'h0E0);
        n = 0;
        do begin
            @(negedge clk_sys);
            #1;
            n++;
        end while ((ack_total - base) < 13 && n < 100);
        arb_mode = 0;
        reset_n = 1'b0;
        #1;
        check("t5_rst_mem_rd",    32'(bus.mem_rd),    32'd0);
        check("t5_rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("t5_rst_vram_data", 32'(bus.vram_data), 32'd0);
        addr_q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        arb_mode = 2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_stray_mem_rd",   32'(bus.mem_rd),   32'd0);
            check("t5_stray_mem_addr", 32'(bus.mem_addr), 32'd0);
        end
        arb_mode = 0;
        tick();
        arb_mode = 1;
        tick();
        pulse_line(9'h0F0);
        check("t5_mem_addr_start", 32'(bus.mem_addr), 32'h1E00);
        wait_idle("t5", 100);
        pulse_line(9'h100);
        read_check("t5_word0",  14'h0000, ram_word({9'h0F0, 5'd0}));
        read_check("t5_word12", 14'h000C, ram_word({9'h0F0, 5'd12}));
        read_check("t5_word13", 14'h000D, ram_word({9'h0F0, 5'd13}));
        read_check("t5_word31", 14'h001F, ram_word({9'h0F0, 5'd31}));
        wait_idle("t5b", 100);

        // 6: random ack delay, one line every 768 clocks
        ack_rand = 1'b1;
        base_u = underrun_cnt;
        prev = 9'h100;
        for (int ln = 0; ln < 80; ln++) begin
            la = 9'($urandom);
            pulse_line(la);
            for (int r = 0; r < 8; r++) begin
                idx = 5'($urandom);
                read_check("t6_display", {9'($urandom), idx}, ram_word({prev, idx}));
            end
            prev = la;
            repeat (768 - 9) tick();
        end
        check("t6_no_underrun", 32'(underrun_cnt - base_u), 32'd0);
        check("t6_sb_drained",  32'(addr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
